// File: rtl/sand_sched.sv
// sand_sched: bottom-up read-modify-write scheduler for one falling-sand frame pass.
// Define SAND_SCHED_SKIP_EN to suppress write-back of words the datapath left unchanged.
module sand_sched #(
    parameter int WORDS_PER_ROW = 40,
    parameter int ROWS          = 480,
    parameter int SPOUT_COL     = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        hold,
    input  logic        spout_en,
    output logic [18:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] upd_region,
    output logic [31:0] upd_floor,
    output logic        upd_screenbegin,
    output logic        upd_screenend,
    output logic        upd_screenbottom,
    output logic        upd_spout,
    input  logic [31:0] upd_new_region,
    input  logic [31:0] upd_new_floor,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    localparam int RW = (ROWS > 2) ? $clog2(ROWS) : 1;
    localparam int CW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

    typedef enum logic [2:0] {
        IDLE, RD_REG, RD_FLR, CAP_FLR, CALC, WR_FLR, WR_REG, NEXT
    } state_t;

    state_t        state_q;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          spout_q, spout_d;
    logic [31:0]   region_q, floor_q, new_region_q, wdata_q;
    logic [18:0]   addr_q;
    logic          rd_q, wr_q, busy_q, done_q, overrun_q;
    logic          begin_q, end_q, bottom_q, spflag_q;
    logic          last_col, last_word, start, adv, go;
    logic          flr_wr, reg_wr;

    function automatic logic [18:0] addr_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return 19'(r) * 19'(WORDS_PER_ROW) + 19'(c);
    endfunction

`ifdef SAND_SCHED_SKIP_EN
    assign flr_wr = upd_new_floor != floor_q;
    assign reg_wr = new_region_q != region_q;
`else
    assign flr_wr = 1'b1;
    assign reg_wr = 1'b1;
`endif

    // Word boundary: WR_REG with hold low advances directly, otherwise NEXT waits.
    always_comb begin
        last_col  = col_q == CW'(WORDS_PER_ROW - 1);
        last_word = last_col && (row_q == '0);
        start     = (state_q == IDLE) && frame_start && !done_q;
        adv       = ((state_q == WR_REG) || (state_q == NEXT)) && !hold;
        go        = start || (adv && !last_word);
        if (start) begin
            row_d   = RW'(ROWS - 2);
            col_d   = '0;
            spout_d = spout_en;
        end else begin
            row_d   = last_col ? row_q - RW'(1) : row_q;
            col_d   = last_col ? '0 : col_q + CW'(1);
            spout_d = spout_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            spout_q      <= 1'b0;
            region_q     <= '0;
            floor_q      <= '0;
            new_region_q <= '0;
            wdata_q      <= '0;
            addr_q       <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            begin_q      <= 1'b0;
            end_q        <= 1'b0;
            bottom_q     <= 1'b0;
            spflag_q     <= 1'b0;
        end else begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            if (frame_start && busy_q)
                overrun_q <= 1'b1;
            unique case (state_q)
                IDLE: busy_q <= 1'b0;
                RD_REG: begin
                    state_q <= RD_FLR;
                    rd_q    <= 1'b1;
                    addr_q  <= addr_of(row_q + RW'(1), col_q);
                end
                RD_FLR: begin
                    state_q  <= CAP_FLR;
                    region_q <= mem_rdata;
                end
                CAP_FLR: begin
                    state_q <= CALC;
                    floor_q <= mem_rdata;
                end
                CALC: begin
                    state_q      <= WR_FLR;
                    new_region_q <= upd_new_region;
                    wdata_q      <= upd_new_floor;
                    wr_q         <= flr_wr;
                    addr_q       <= addr_of(row_q + RW'(1), col_q);
                end
                WR_FLR: begin
                    state_q <= WR_REG;
                    wdata_q <= new_region_q;
                    wr_q    <= reg_wr;
                    addr_q  <= addr_of(row_q, col_q);
                end
                WR_REG, NEXT: begin
                    if (hold) begin
                        state_q <= NEXT;
                    end else if (last_word) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
            if (go) begin
                state_q  <= RD_REG;
                busy_q   <= 1'b1;
                row_q    <= row_d;
                col_q    <= col_d;
                spout_q  <= spout_d;
                rd_q     <= 1'b1;
                addr_q   <= addr_of(row_d, col_d);
                begin_q  <= col_d == '0;
                end_q    <= col_d == CW'(WORDS_PER_ROW - 1);
                bottom_q <= row_d == RW'(ROWS - 2);
                spflag_q <= spout_d && (row_d == '0) && (col_d == CW'(SPOUT_COL));
            end
        end
    end

    assign mem_addr         = addr_q;
    assign mem_rd           = rd_q;
    assign mem_wr           = wr_q;
    assign mem_wdata        = wdata_q;
    assign upd_region       = region_q;
    assign upd_floor        = floor_q;
    assign upd_screenbegin  = begin_q;
    assign upd_screenend    = end_q;
    assign upd_screenbottom = bottom_q;
    assign upd_spout        = spflag_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign overrun          = overrun_q;

endmodule
